// File: rtl/reg_file_pc_sb.sv
// ARM-style register file with the PC held at PC_IDX, same-cycle write bypass,
// branch-and-link return-address write and a pending-write scoreboard.
module reg_file_pc_sb #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int PC_IDX      = 15,
  parameter int LR_IDX      = 14,
  parameter int PC_STEP     = 4,
  parameter int PC_READ_OFS = 8,
  parameter int RESET_PC    = 0,
  parameter int BYPASS      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeDestination,
  input  logic [DATA_W-1:0] writeData,
  input  logic              linkBit,
  input  logic              pcAdvance,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] pcOut,
  output logic              writeToPC,
  input  logic              reserveEnable,
  input  logic [ADDR_W-1:0] reserveReg,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pendingCount
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(LR_IDX);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] RD_OFS = DATA_W'(PC_READ_OFS);
  localparam logic BYP = (BYPASS != 0);

  // regs[PC_A] is never written and never read; the PC lives in pc_q
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   pc_q, pc_nxt;
  logic [NUM_REGS-1:0] busy_q, busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                gen_write;
  logic                byp1, byp2;

  assign writeToPC = writeEnable && (writeDestination == PC_A);
  assign gen_write = writeEnable && (writeDestination != PC_A);
  assign pcOut     = pc_q;

  // link result is never bypassed, so a same-cycle LR read sees the stored value
  assign byp1 = BYP && gen_write && (writeDestination == readReg1) && !(linkBit && readReg1 == LR_A);
  assign byp2 = BYP && gen_write && (writeDestination == readReg2) && !(linkBit && readReg2 == LR_A);

  always_comb begin
    readData1 = regs[readReg1];
    if (readReg1 == PC_A)
      readData1 = pc_q + RD_OFS;
    else if (byp1)
      readData1 = writeData;
  end

  always_comb begin
    readData2 = regs[readReg2];
    if (readReg2 == PC_A)
      readData2 = pc_q + RD_OFS;
    else if (byp2)
      readData2 = writeData;
  end

  assign busy1 = busy_q[readReg1] && !(BYP && writeEnable && writeDestination == readReg1);
  assign busy2 = busy_q[readReg2] && !(BYP && writeEnable && writeDestination == readReg2);

  always_comb begin
    pc_nxt = pc_q;
    if (writeToPC)
      pc_nxt = writeData;
    else if (pcAdvance)
      pc_nxt = pc_q + STEP;
  end

  // reserve is applied last so it wins over a same-cycle write or link
  always_comb begin
    busy_nxt = busy_q;
    if (gen_write)
      busy_nxt[writeDestination] = 1'b0;
    if (linkBit)
      busy_nxt[LR_A] = 1'b0;
    if (reserveEnable)
      busy_nxt[reserveReg] = 1'b1;
    busy_nxt[PC_A] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      pc_q         <= DATA_W'(RESET_PC);
      busy_q       <= '0;
      pendingCount <= '0;
    end else begin
      if (gen_write)
        regs[writeDestination] <= writeData;
      if (linkBit)
        regs[LR_A] <= pc_q + STEP;
      pc_q         <= pc_nxt;
      busy_q       <= busy_nxt;
      pendingCount <= cnt_nxt;
    end
  end

endmodule
